// File: rtl/mem_rd_arbiter.sv
// mem_rd_arbiter: 4-way round-robin read arbiter with a 4-entry outstanding-read tracking table.
// Optional per-entry age timeout is compiled in when MRA_TIMEOUT_EN is defined.
module mem_rd_arbiter #(
    parameter int NREQ = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [16*NREQ-1:0]   req_address,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rd_en,
    output logic [15:0]          rd_address,
    input  logic                 rd_ret_ack,
    input  logic [15:0]          rd_ret_address,
    input  logic [15:0]          rd_ret_data,
    output logic [NREQ-1:0]      resp_valid,
    output logic [15:0]          resp_data,
    output logic [2:0]           outstanding,
    output logic                 err_unmatched,
    output logic                 err_timeout
);
    localparam int NENT = 4;

    logic [NENT-1:0] ent_valid;
    logic [15:0]     ent_addr  [NENT];
    logic [1:0]      ent_owner [NENT];
    logic [1:0]      rr_ptr;

    logic [15:0]     req_addr [NREQ];
    logic [NREQ-1:0] req_blocked;
    logic            grant_hit;
    logic [1:0]      grant_idx;
    logic            accept;
    logic            free_hit;
    logic [1:0]      free_idx;
    logic            ret_hit;
    logic [1:0]      ret_idx;
    logic [NENT-1:0] to_expire;
    logic [NENT-1:0] set_mask;
    logic [NENT-1:0] clear_mask;

    for (genvar i = 0; i < NREQ; i++) begin : g_addr
        assign req_addr[i] = req_address[16*i +: 16];
    end

    // A requester whose address is already in flight is skipped, not stalled on.
    always_comb begin
        req_blocked = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            for (int unsigned e = 0; e < NENT; e++) begin
                if (ent_valid[e] && ent_addr[e] == req_addr[i])
                    req_blocked[i] = 1'b1;
            end
        end
    end

    always_comb begin
        grant_hit = 1'b0;
        grant_idx = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!grant_hit && req_valid[rr_ptr + 2'(k)] && !req_blocked[rr_ptr + 2'(k)]) begin
                grant_hit = 1'b1;
                grant_idx = rr_ptr + 2'(k);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (!reset && !(&ent_valid) && grant_hit)
            req_ready[grant_idx] = 1'b1;
    end

    assign accept = |(req_valid & req_ready);

    always_comb begin
        free_hit = 1'b0;
        free_idx = '0;
        for (int unsigned e = 0; e < NENT; e++) begin
            if (!free_hit && !ent_valid[e]) begin
                free_hit = 1'b1;
                free_idx = 2'(e);
            end
        end
    end

    always_comb begin
        ret_hit = 1'b0;
        ret_idx = '0;
        for (int unsigned e = 0; e < NENT; e++) begin
            if (!ret_hit && rd_ret_ack && ent_valid[e] && ent_addr[e] == rd_ret_address) begin
                ret_hit = 1'b1;
                ret_idx = 2'(e);
            end
        end
    end

    // Freed and allocated entries never coincide: allocation only targets entries already free.
    always_comb begin
        set_mask   = '0;
        clear_mask = to_expire;
        if (accept)
            set_mask[free_idx] = 1'b1;
        if (ret_hit)
            clear_mask[ret_idx] = 1'b1;
    end

    always_comb begin
        outstanding = '0;
        for (int unsigned e = 0; e < NENT; e++)
            outstanding = outstanding + 3'(ent_valid[e]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ent_valid     <= '0;
            rr_ptr        <= '0;
            rd_en         <= 1'b0;
            rd_address    <= '0;
            resp_valid    <= '0;
            resp_data     <= '0;
            err_unmatched <= 1'b0;
            for (int unsigned e = 0; e < NENT; e++) begin
                ent_addr[e]  <= '0;
                ent_owner[e] <= '0;
            end
        end else begin
            rd_en         <= accept;
            err_unmatched <= rd_ret_ack && !ret_hit;
            resp_valid    <= ret_hit ? (NREQ'(1) << ent_owner[ret_idx]) : '0;
            if (ret_hit)
                resp_data <= rd_ret_data;
            if (accept) begin
                rd_address          <= req_addr[grant_idx];
                rr_ptr              <= grant_idx + 2'd1;
                ent_addr[free_idx]  <= req_addr[grant_idx];
                ent_owner[free_idx] <= grant_idx;
            end
            ent_valid <= (ent_valid & ~clear_mask) | set_mask;
        end
    end

`ifdef MRA_TIMEOUT_EN
    logic [7:0] ent_age [NENT];

    // An entry expires on the edge where its age would become 255; a matching return wins.
    always_comb begin
        to_expire = '0;
        for (int unsigned e = 0; e < NENT; e++)
            to_expire[e] = ent_valid[e] && ent_age[e] == 8'd254 && !(ret_hit && ret_idx == 2'(e));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_timeout <= 1'b0;
            for (int unsigned e = 0; e < NENT; e++)
                ent_age[e] <= '0;
        end else begin
            err_timeout <= |to_expire;
            for (int unsigned e = 0; e < NENT; e++) begin
                if (accept && free_idx == 2'(e))
                    ent_age[e] <= '0;
                else if (ent_valid[e])
                    ent_age[e] <= ent_age[e] + 8'd1;
            end
        end
    end
`else
    assign to_expire   = '0;
    assign err_timeout = 1'b0;
`endif

endmodule
